// File: rtl/level_coin_tracker_pkg.sv
// Shared types for the level coin tracker: tile codes, tile write request,
// grid dimensions and small mask helpers used by the write arbiter.
package level_pkg;

  typedef enum logic [7:0] {
    BDR = 8'd0,
    SKY = 8'd1,
    BLK = 8'd2,
    GND = 8'd3,
    TKN = 8'd4
  } tile_t;

  typedef struct packed {
    logic [4:0] x;
    logic [3:0] y;
    logic [7:0] data;
  } tile_wr_t;

  typedef enum logic {WR_IDLE, WR_ISSUE} wr_state_t;

  localparam int GRID_COLS = 17;
  localparam int GRID_ROWS = 12;

  // Index of the lowest set bit (0 when the mask is empty).
  function automatic logic [3:0] lowest_idx(input logic [15:0] m);
    lowest_idx = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (m[i]) lowest_idx = 4'(i);
  endfunction

  // Number of set bits in a 16-bit mask.
  function automatic logic [4:0] popcount(input logic [15:0] m);
    popcount = 5'd0;
    for (int i = 0; i < 16; i++)
      popcount = popcount + {4'd0, m[i]};
  endfunction

endpackage

// File: rtl/level_coin_tracker_coin_hit_detect.sv
// Per-coin overlap detector: Mario box [x, x+MARIO_WIDTH) against the coin
// tile [cx*BW, cx*BW+BW), both axes, registered once. Negative Mario
// coordinates are treated as off-screen and never hit.
module coin_hit_detect
  import level_pkg::*;
#(
  parameter logic [4:0] COIN_X      = 5'd0,
  parameter logic [3:0] COIN_Y      = 4'd0,
  parameter int         MARIO_WIDTH = 42,
  parameter int         BLOCK_WIDTH = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] mario_x,
  input  logic signed [31:0] mario_y,
  output logic               hit_q
);

  localparam int CX = int'(COIN_X) * BLOCK_WIDTH;
  localparam int CY = int'(COIN_Y) * BLOCK_WIDTH;

  logic hit_d;

  // Half-open interval intersection on both axes, signed compare.
  always_comb begin
    hit_d = (mario_x >= 0) && (mario_y >= 0) &&
            (mario_x < CX + BLOCK_WIDTH) && (CX < mario_x + MARIO_WIDTH) &&
            (mario_y < CY + BLOCK_WIDTH) && (CY < mario_y + MARIO_WIDTH);
  end

  // Stage-1 register of the overlap result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit_q <= 1'b0;
    else     hit_q <= hit_d;
  end

endmodule

// File: rtl/level_coin_tracker.sv
// Coin manager for one level: latches collected coins, keeps count and a
// saturating score, flags level completion and serialises background tile
// rewrites (SKY on collect, TKN on restart) over a valid/ready port.
// Optional macro COIN_COMBO_BONUS_EN doubles coin value while a combo timer runs.
module level_coin_tracker
  import level_pkg::*;
#(
  parameter int                     NUM_COINS   = 4,
  parameter logic [5*NUM_COINS-1:0] COIN_X      = '0,
  parameter logic [4*NUM_COINS-1:0] COIN_Y      = '0,
  parameter logic [7:0]             SKY         = 8'd1,
  parameter logic [7:0]             TKN         = 8'd4,
  parameter int                     MARIO_WIDTH = 42,
  parameter int                     BLOCK_WIDTH = 40,
  parameter int                     COIN_VALUE  = 100,
  parameter int                     SCORE_WIDTH = 16
) (
  input  logic                   vga_clock,
  input  logic                   reset,
  input  logic signed [31:0]     mario_x,
  input  logic signed [31:0]     mario_y,
  input  logic                   level_restart,
  output logic                   tile_wr_valid,
  input  logic                   tile_wr_ready,
  output logic [4:0]             tile_wr_x,
  output logic [3:0]             tile_wr_y,
  output logic [7:0]             tile_wr_data,
  output logic [NUM_COINS-1:0]   collected,
  output logic [4:0]             coin_count,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   collect_pulse,
  output logic                   level_complete
);

  localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_WIDTH) - 64'd1);

  logic [NUM_COINS-1:0]   hit_q, new_hit, served_mask;
  logic [NUM_COINS-1:0]   collected_q, collected_d;
  logic [NUM_COINS-1:0]   pend_clr_q, pend_clr_d, pend_rst_q, pend_rst_d;
  logic [4:0]             count_q, count_d, new_cnt;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic                   pulse_q, pulse_d, done_q, done_d;
  logic [31:0]            coin_val, score_sum;
  wr_state_t              state_q, state_d;
  tile_wr_t               wr_q, wr_d;
  logic [3:0]             idx_q, idx_d, sel_idx;
  logic                   kind_rst_q, kind_rst_d, wr_fire;

  for (genvar i = 0; i < NUM_COINS; i++) begin : g_coin
    coin_hit_detect #(
      .COIN_X      (COIN_X[5*i +: 5]),
      .COIN_Y      (COIN_Y[4*i +: 4]),
      .MARIO_WIDTH (MARIO_WIDTH),
      .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_hit (
      .clk     (vga_clock),
      .rst     (reset),
      .mario_x (mario_x),
      .mario_y (mario_y),
      .hit_q   (hit_q[i])
    );
  end

`ifdef COIN_COMBO_BONUS_EN
  logic [7:0] combo_q, combo_d;

  // Combo window reloads on every collection and counts down to zero.
  always_comb begin
    combo_d = combo_q;
    if (level_restart)        combo_d = 8'd0;
    else if (|new_hit)        combo_d = 8'd120;
    else if (combo_q != 8'd0) combo_d = combo_q - 8'd1;
  end

  // Combo timer register.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) combo_q <= 8'd0;
    else       combo_q <= combo_d;
  end

  assign coin_val = (combo_q != 8'd0) ? 32'(2 * COIN_VALUE) : 32'(COIN_VALUE);
`else
  assign coin_val = 32'(COIN_VALUE);
`endif

  // Stage 2: latch new hits, update counters and the pending write masks.
  // Restart wins over any same-cycle collection and queues TKN restores.
  always_comb begin
    new_hit   = hit_q & ~collected_q;
    new_cnt   = popcount(16'(new_hit));
    score_sum = 32'(score_q) + 32'(new_cnt) * coin_val;
    for (int i = 0; i < NUM_COINS; i++)
      served_mask[i] = wr_fire && (idx_q == 4'(i));

    collected_d = collected_q | new_hit;
    count_d     = count_q + new_cnt;
    score_d     = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_WIDTH-1:0]
                                          : score_sum[SCORE_WIDTH-1:0];
    pulse_d     = |new_hit;
    done_d      = done_q | (&collected_q);

    pend_clr_d = pend_clr_q;
    pend_rst_d = pend_rst_q;
    if (kind_rst_q) pend_rst_d = pend_rst_q & ~served_mask;
    else            pend_clr_d = pend_clr_q & ~served_mask;

    if (level_restart) begin
      collected_d = '0;
      count_d     = 5'd0;
      score_d     = '0;
      pulse_d     = 1'b0;
      done_d      = 1'b0;
      pend_clr_d  = '0;
      pend_rst_d  = pend_rst_d | collected_q;
    end else begin
      pend_clr_d  = pend_clr_d | new_hit;
    end
  end

  // Collection state registers.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      collected_q <= '0;
      count_q     <= 5'd0;
      score_q     <= '0;
      pulse_q     <= 1'b0;
      done_q      <= 1'b0;
      pend_clr_q  <= '0;
      pend_rst_q  <= '0;
    end else begin
      collected_q <= collected_d;
      count_q     <= count_d;
      score_q     <= score_d;
      pulse_q     <= pulse_d;
      done_q      <= done_d;
      pend_clr_q  <= pend_clr_d;
      pend_rst_q  <= pend_rst_d;
    end
  end

  // Write FSM next state: restores take priority, lowest coin index first;
  // the request is captured on IDLE->ISSUE and held until accepted.
  always_comb begin
    sel_idx    = (|pend_rst_q) ? lowest_idx(16'(pend_rst_q)) : lowest_idx(16'(pend_clr_q));
    state_d    = state_q;
    wr_d       = wr_q;
    idx_d      = idx_q;
    kind_rst_d = kind_rst_q;
    case (state_q)
      WR_IDLE: begin
        if ((|pend_rst_q) || (|pend_clr_q)) begin
          state_d    = WR_ISSUE;
          idx_d      = sel_idx;
          kind_rst_d = |pend_rst_q;
          wr_d.data  = (|pend_rst_q) ? TKN : SKY;
          for (int i = 0; i < NUM_COINS; i++) begin
            if (sel_idx == 4'(i)) begin
              wr_d.x = COIN_X[5*i +: 5];
              wr_d.y = COIN_Y[4*i +: 4];
            end
          end
        end
      end
      WR_ISSUE: if (tile_wr_ready) state_d = WR_IDLE;
      default:  state_d = WR_IDLE;
    endcase
  end

  // Write FSM outputs: valid purely from state so reset drops it at once.
  always_comb begin
    tile_wr_valid = (state_q == WR_ISSUE);
    wr_fire       = tile_wr_valid && tile_wr_ready;
  end

  // Write FSM state register.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) state_q <= WR_IDLE;
    else       state_q <= state_d;
  end

  // Captured write request and its pending-set origin.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      wr_q       <= '0;
      idx_q      <= 4'd0;
      kind_rst_q <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      idx_q      <= idx_d;
      kind_rst_q <= kind_rst_d;
    end
  end

  assign tile_wr_x      = wr_q.x;
  assign tile_wr_y      = wr_q.y;
  assign tile_wr_data   = wr_q.data;
  assign collected      = collected_q;
  assign coin_count     = count_q;
  assign score          = score_q;
  assign collect_pulse  = pulse_q;
  assign level_complete = done_q;

endmodule

// File: tb/tb_level_coin_tracker.sv
// Scoreboard bench: stimulus pushes expected status snapshots and tile writes;
// a negedge monitor pops and compares on collect_pulse and on handshakes.
module tb_level_coin_tracker;

  localparam int NC = 4;
  localparam int SW = 8;

  logic               vga_clock = 1'b0;
  logic               reset = 1'b1;
  logic signed [31:0] mario_x, mario_y;
  logic               level_restart, tile_wr_ready;
  logic               tile_wr_valid;
  logic [4:0]         tile_wr_x;
  logic [3:0]         tile_wr_y;
  logic [7:0]         tile_wr_data;
  logic [NC-1:0]      collected;
  logic [4:0]         coin_count;
  logic [SW-1:0]      score;
  logic               collect_pulse, level_complete;

  always #5 vga_clock = ~vga_clock;

  // coins: c0 (6,6)  c1 (14,2)  c2 (3,5)  c3 (4,5)
  level_coin_tracker #(
    .NUM_COINS   (NC),
    .COIN_X      ({5'd4, 5'd3, 5'd14, 5'd6}),
    .COIN_Y      ({4'd5, 4'd5, 4'd2, 4'd6}),
    .SCORE_WIDTH (SW)
  ) dut (
    .vga_clock      (vga_clock),
    .reset          (reset),
    .mario_x        (mario_x),
    .mario_y        (mario_y),
    .level_restart  (level_restart),
    .tile_wr_valid  (tile_wr_valid),
    .tile_wr_ready  (tile_wr_ready),
    .tile_wr_x      (tile_wr_x),
    .tile_wr_y      (tile_wr_y),
    .tile_wr_data   (tile_wr_data),
    .collected      (collected),
    .coin_count     (coin_count),
    .score          (score),
    .collect_pulse  (collect_pulse),
    .level_complete (level_complete)
  );

  typedef struct packed { logic [4:0] x; logic [3:0] y; logic [7:0] d; } wr_exp_t;
  typedef struct packed { logic [3:0] mask; logic [4:0] cnt; logic [7:0] sc; } st_exp_t;

  wr_exp_t wq[$];
  st_exp_t sq[$];
  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every accepted write and every collect strobe must match the head of its queue.
  always @(negedge vga_clock) begin
    wr_exp_t we;
    st_exp_t se;
    if (!reset && tile_wr_valid && tile_wr_ready) begin
      if (wq.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_write: got x=%0d y=%0d data=%0d expected no write",
                 tile_wr_x, tile_wr_y, tile_wr_data);
      end else begin
        we = wq.pop_front();
        chk("wr_x", 32'(tile_wr_x), 32'(we.x));
        chk("wr_y", 32'(tile_wr_y), 32'(we.y));
        chk("wr_data", 32'(tile_wr_data), 32'(we.d));
      end
    end
    if (!reset && collect_pulse) begin
      if (sq.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_pulse: got collected=%b score=%0d expected no pulse",
                 collected, score);
      end else begin
        se = sq.pop_front();
        chk("collected", 32'(collected), 32'(se.mask));
        chk("coin_count", 32'(coin_count), 32'(se.cnt));
        chk("score", 32'(score), 32'(se.sc));
      end
    end
  end

  task automatic step();
    @(posedge vga_clock); #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin @(negedge vga_clock); n++; end while (!tile_wr_valid && n < 30);
    chk(name, 32'(tile_wr_valid), 32'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    @(negedge vga_clock);
    while ((wq.size() != 0 || tile_wr_valid) && n < 200) begin
      @(negedge vga_clock); n++;
    end
    chk(name, 32'(wq.size()), 32'd0);
  endtask

  task automatic restart_pulse();
    step(); level_restart = 1'b1;
    step(); level_restart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mario_x = -100; mario_y = -100; level_restart = 1'b0; tile_wr_ready = 1'b1;
    repeat (2) @(negedge vga_clock);
    chk("rst_valid", 32'(tile_wr_valid), 0);
    chk("rst_collected", 32'(collected), 0);
    chk("rst_count", 32'(coin_count), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_pulse", 32'(collect_pulse), 0);
    chk("rst_complete", 32'(level_complete), 0);
    chk("rst_wr_x", 32'(tile_wr_x), 0);
    step(); reset = 1'b0;

    // single coin: hit on c0 only, 2-cycle latency, one SKY write
    sq.push_back('{4'b0001, 5'd1, 8'd100});
    wq.push_back('{5'd6, 4'd6, 8'd1});
    step(); mario_x = 240; mario_y = 240;
    @(posedge vga_clock); @(negedge vga_clock);
    chk("latency_not_1", 32'(collected), 0);
    drain("t1_drain");
    mario_x = -100; mario_y = -100;

    // restart restores c0 with TKN
    wq.push_back('{5'd6, 4'd6, 8'd4});
    restart_pulse();
    @(negedge vga_clock);
    chk("t1r_collected", 32'(collected), 0);
    chk("t1r_score", 32'(score), 0);
    drain("t1r_drain");

    // double hit c2+c3 in one cycle, writes stalled 10 cycles
    tile_wr_ready = 1'b0;
    sq.push_back('{4'b1100, 5'd2, 8'd200});
    wq.push_back('{5'd3, 4'd5, 8'd1});
    wq.push_back('{5'd4, 4'd5, 8'd1});
    step(); mario_x = 150; mario_y = 200;
    wait_valid("t2_valid_timeout");
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 32'(tile_wr_valid), 1);
      chk("stall_x", 32'(tile_wr_x), 3);
      chk("stall_y", 32'(tile_wr_y), 5);
      chk("stall_data", 32'(tile_wr_data), 1);
      @(negedge vga_clock);
    end
    step(); tile_wr_ready = 1'b1;
    @(negedge vga_clock);
    @(negedge vga_clock);
    chk("gap_valid", 32'(tile_wr_valid), 0);
    @(negedge vga_clock);
    chk("next_valid", 32'(tile_wr_valid), 1);
    chk("next_x", 32'(tile_wr_x), 4);
    drain("t2_drain");
    mario_x = -100; mario_y = -100;

    // saturation: 200+100 -> 255 (8-bit score)
    sq.push_back('{4'b1101, 5'd3, 8'd255});
    wq.push_back('{5'd6, 4'd6, 8'd1});
    step(); mario_x = 240; mario_y = 240;
    drain("t3a_drain");
    chk("not_complete", 32'(level_complete), 0);
    mario_x = -100; mario_y = -100;

    // last coin completes level; restart while its SKY write is stalled
    tile_wr_ready = 1'b0;
    sq.push_back('{4'b1111, 5'd4, 8'd255});
    wq.push_back('{5'd14, 4'd2, 8'd1});
    step(); mario_x = 560; mario_y = 80;
    wait_valid("t3b_valid_timeout");
    chk("complete", 32'(level_complete), 1);
    wq.push_back('{5'd6, 4'd6, 8'd4});
    wq.push_back('{5'd14, 4'd2, 8'd4});
    wq.push_back('{5'd3, 4'd5, 8'd4});
    wq.push_back('{5'd4, 4'd5, 8'd4});
    step(); level_restart = 1'b1; mario_x = -100; mario_y = -100;
    step(); level_restart = 1'b0;
    @(negedge vga_clock);
    chk("t3r_score", 32'(score), 0);
    chk("t3r_collected", 32'(collected), 0);
    chk("t3r_count", 32'(coin_count), 0);
    chk("t3r_complete", 32'(level_complete), 0);
    chk("t3r_valid_held", 32'(tile_wr_valid), 1);
    chk("t3r_x_held", 32'(tile_wr_x), 14);
    step(); tile_wr_ready = 1'b1;
    drain("t3r_drain");

    // reset during ISSUE drops valid immediately
    tile_wr_ready = 1'b0;
    sq.push_back('{4'b0001, 5'd1, 8'd100});
    step(); mario_x = 240; mario_y = 240;
    wait_valid("t4_valid_timeout");
    #2 reset = 1'b1;
    #1;
    chk("t4_valid_drop", 32'(tile_wr_valid), 0);
    chk("t4_collected", 32'(collected), 0);
    chk("t4_score", 32'(score), 0);
    chk("t4_count", 32'(coin_count), 0);
    mario_x = -100; mario_y = -100; tile_wr_ready = 1'b1;
    step(); reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge vga_clock);
      chk("t4_idle", 32'(tile_wr_valid), 0);
    end

    chk("status_queue_empty", 32'(sq.size()), 0);
    chk("write_queue_empty", 32'(wq.size()), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/level_coin_tracker.md
Name: level_coin_tracker

Overview:
- Parametrised coin/token manager for a level, generalising the per-level fixed two-coin logic to NUM_COINS coins.
- Detects Mario-to-coin overlap and latches a collected mask, so simultaneous touches are never dropped.
- Maintains coin count and saturating score, and raises level_complete.
- Serialises background tile rewrites (TKN->SKY on collect, SKY->TKN on restart) through a valid/ready write port into the level's background map.

Parameters:
- NUM_COINS, 4, number of coins (1..16).
- COIN_X, {16'd0}, packed NUM_COINS x 5-bit tile column per coin; coin i at bits [5i+4:5i].
- COIN_Y, {16'd0}, packed NUM_COINS x 4-bit tile row per coin; coin i at bits [4i+3:4i].
- SKY, 1, tile code written on collect.
- TKN, 4, tile code written on restore.
- MARIO_WIDTH, 42, Mario bounding-box side in pixels.
- BLOCK_WIDTH, 40, tile side in pixels.
- COIN_VALUE, 100, score added per coin.
- SCORE_WIDTH, 16, score register width.

Ports:
- vga_clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- mario_x  in  32 (int)  Mario left pixel.
- mario_y  in  32 (int)  Mario bottom pixel, same frame as tile origin (x*BLOCK_WIDTH, y*BLOCK_WIDTH).
- level_restart  in  1  sync one-cycle pulse: un-collect all coins.
- tile_wr_valid  out  1  tile write request.
- tile_wr_ready  in  1  background owner accepts write.
- tile_wr_x  out  5  tile column.
- tile_wr_y  out  4  tile row.
- tile_wr_data  out  8  tile code (SKY or TKN).
- collected  out  NUM_COINS  collected mask.
- coin_count  out  5  popcount of collected.
- score  out  SCORE_WIDTH  accumulated score.
- collect_pulse  out  1  one-cycle strobe, cycle after any new collection.
- level_complete  out  1  sticky, all coins collected.

Behaviour:
- Reset values (async assert): all outputs 0, including tile_wr_valid, which drops immediately even mid-handshake. Pending queue and FSM clear to IDLE.
- Overlap (stage 1, registered): hit[i] = boxes intersect with half-open ranges [p, p+W). Mario uses W = MARIO_WIDTH; coins use W = BLOCK_WIDTH. Use signed 32-bit compare, so negative Mario coordinates never hit.
- Collect (stage 2): new = hit & ~collected.
  - collected |= new; pend_clr |= new.
  - coin_count += popcount(new); score += popcount(new)*COIN_VALUE, saturating at 2^SCORE_WIDTH-1.
  - collect_pulse = |new. Latency from mario_* change to collected/score: 2 cycles.
  - Simultaneous hits on k coins: all k latched in the same cycle; score rises by k*COIN_VALUE.
- level_complete: set the cycle after collected becomes all-ones. It stays set until reset or level_restart.
- level_restart (priority over same-cycle collection):
  - collected, coin_count, score, level_complete cleared next cycle.
  - pend_clr cleared; pend_rst set to the previous collected mask.
  - Hits in the restart cycle are ignored.
- Write FSM states:
  - IDLE: if pend_rst nonzero, go to ISSUE with the lowest set index, data=TKN. Else if pend_clr nonzero, go to ISSUE with the lowest index, data=SKY. pend_rst has priority over pend_clr.
  - ISSUE: tile_wr_valid=1; x, y, data stable until ready. On valid&&ready, clear the served pending bit and return to IDLE. Max one write per 2 cycles.
  - A restart arriving during ISSUE does not abort the transfer. The current write completes, then restore writes follow.
  - A coin cleared by restart while its SKY write is in flight is restored afterwards by its TKN entry.
- tile_wr_valid never deasserts without ready, except on reset.

Optional Feature:
- Macro COIN_COMBO_BONUS_EN.
- When defined:
  - 8-bit combo_timer loads 120 on each collection and decrements to 0.
  - Any collection while combo_timer>0 scores 2*COIN_VALUE per coin, still saturating.
  - Timer clears on reset and restart.
- When undefined: timer logic is absent and every coin scores COIN_VALUE.

Decomposition:
- Package level_pkg holds:
  - tile codes BDR/SKY/BLK/GND/TKN as typedef enum logic [7:0] tile_t;
  - tile_wr_t struct {x, y, data};
  - constants GRID_COLS=17, GRID_ROWS=12.
- Sub-module coin_hit_detect (one per coin, generate loop): combinational box overlap plus stage-1 register. The top keeps the masks, counters and write FSM.

Test Plan:
- Two coins at (6,6) and (14,2), BLOCK_WIDTH=40; place Mario at (240,240) -> hit on coin0 only, collected=01 and score=100 two cycles later. Then one write x=6,y=6,data=SKY.
- Coin0 at (3,5), coin1 at (4,5); Mario at (150,200) overlaps both -> collected=11 in one cycle, score=200, coin_count=2, collect_pulse high exactly one cycle. Writes in order: coin0, then coin1.
- Hold tile_wr_ready=0 for 10 cycles -> valid stays high with x/y/data stable. Ready=1 -> handshake in one cycle, next request 2 cycles later.
- Collect all 4 coins -> level_complete=1. Pulse level_restart mid-write -> current write completes, 4 TKN writes follow, score=0, level_complete=0.
- Assert reset during ISSUE -> tile_wr_valid=0 immediately (same cycle), all outputs 0, no writes after release.
- Set score near max (SCORE_WIDTH=8, COIN_VALUE=100), collect 3 coins -> score=255 saturated. With COIN_COMBO_BONUS_EN, two collections 50 cycles apart -> second adds 200.
